x_mpc_rx_frame: RTL and testbench

- Downstream of the MPC input DDR demux; consumes its 40 MHz first/second time-slice words.
- Assembles the two-bx MPC response (frame0, frame1) to each LCT the TMB transmits, at a programmable delay after the transmit strobe.
- Extracts the per-LCT accept bits, flags missing (idle) responses and overlap errors, and keeps saturating response/error counters.

---
 rtl/x_mpc_rx_frame.sv | 174 +++++++++++++++++
 tb/tb_x_mpc_rx_frame.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/x_mpc_rx_frame.sv
// x_mpc_rx_frame
//   Assembles the two-bx MPC response (frame0, frame1) to each LCT frame the
//   TMB transmits. A 16-deep shift register of transmit strobes marks the bx
//   where frame0 is expected (mpc_delay clocks after the strobe); the frame
//   word of that bx and the one that follows it are captured. The captured
//   frames are then decoded into accept bits and an idle flag, and two
//   saturating counters are kept.
//
//   Optional feature: define MPC_RX_PARITY_EN to check even parity over each
//   2*WIDTH-bit frame. Parity errors are reported on rsp_parity_err and are
//   counted in err_count. Without the macro, rsp_parity_err is tied to 0.
//
// Ports
//   clock, reset_n         40 MHz clock, async active-low reset
//   din1st, din2nd         demux time slices (idle = all ones)
//   mpc_xmit               one-clock strobe: LCT frame sent this bx
//   mpc_delay              clocks from strobe to expected frame0
//   cnt_clear              synchronous clear of both counters
//   rsp_valid              one-clock pulse: rsp_* fields updated
//   rsp_frame0/1           captured frames, {din2nd,din1st}
//   rsp_accept             {LCT1 accepted, LCT0 accepted}
//   rsp_idle_err           a frame was all ones (no response)
//   rsp_parity_err         frame parity error (MPC_RX_PARITY_EN only)
//   busy                   capture in progress (second frame pending)
//   rsp_count, err_count   saturating response / error counters
module x_mpc_rx_frame #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   din1st,
  input  logic [WIDTH-1:0]   din2nd,
  input  logic               mpc_xmit,
  input  logic [3:0]         mpc_delay,
  input  logic               cnt_clear,
  output logic               rsp_valid,
  output logic [2*WIDTH-1:0] rsp_frame0,
  output logic [2*WIDTH-1:0] rsp_frame1,
  output logic [1:0]         rsp_accept,
  output logic               rsp_idle_err,
  output logic               rsp_parity_err,
  output logic               busy,
  output logic [CNT_W-1:0]   rsp_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int FW = 2*WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_F1 = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] word_r;
  logic [FW-1:0] f0_hold;
  logic [15:0]   sr;
  logic          cap0;
  logic          take_f0;
  logic          complete;
  logic          overlap;
  logic          idle_now;
  logic          par_now;
  logic          err_now;
  logic [1:0]    acc_now;
  logic [1:0]    err_inc;
  logic [CNT_W:0] rsp_sum;
  logic [CNT_W:0] err_sum;

  // Input register and transmit-strobe history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_r <= '1;
      sr     <= '0;
    end else begin
      word_r <= {din2nd, din1st};
      sr     <= {sr[14:0], mpc_xmit};
    end
  end

  // Live delay select: sr[d] goes high d edges after the strobe edge, the
  // same edge that loads word_r with the frame0 bx.
  assign cap0 = sr[mpc_delay];

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state. F1 always lasts exactly one clock.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cap0) state_nxt = S_F1;
      S_F1:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs / strobes
  always_comb begin
    busy     = (state == S_F1);
    take_f0  = (state == S_IDLE) && cap0;
    complete = (state == S_F1);
    // A second capture request while frame1 is still pending is dropped.
    overlap  = (state == S_F1) && cap0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     f0_hold <= '0;
    else if (take_f0) f0_hold <= word_r;
  end

  // Decode of the frame pair being completed (f0_hold, word_r = frame1)
  assign idle_now = (f0_hold == '1) || (word_r == '1);
  assign acc_now  = idle_now ? 2'b00 : {word_r[FW-1], f0_hold[FW-1]};

`ifdef MPC_RX_PARITY_EN
  // Even parity per frame; all ones has even parity so idles never trip it.
  assign par_now = (^f0_hold) | (^word_r);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      rsp_parity_err <= 1'b0;
    else if (complete) rsp_parity_err <= par_now;
  end
`else
  assign par_now        = 1'b0;
  assign rsp_parity_err = 1'b0;
`endif

  assign err_now = idle_now | par_now;

  // Response fields hold until the next completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid    <= 1'b0;
      rsp_frame0   <= '0;
      rsp_frame1   <= '0;
      rsp_accept   <= 2'b00;
      rsp_idle_err <= 1'b0;
    end else begin
      rsp_valid <= complete;
      if (complete) begin
        rsp_frame0   <= f0_hold;
        rsp_frame1   <= word_r;
        rsp_accept   <= acc_now;
        rsp_idle_err <= idle_now;
      end
    end
  end

  // Counters: an overlap and an erroneous completion on the same edge add 2.
  always_comb begin
    err_inc = 2'd0;
    if (complete && err_now) err_inc = err_inc + 2'd1;
    if (overlap)             err_inc = err_inc + 2'd1;
  end

  assign rsp_sum = {1'b0, rsp_count} + {{CNT_W{1'b0}}, complete};
  assign err_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, err_inc};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_count <= '0;
      err_count <= '0;
    end else if (cnt_clear) begin
      rsp_count <= '0;
      err_count <= '0;
    end else begin
      rsp_count <= rsp_sum[CNT_W] ? '1 : rsp_sum[CNT_W-1:0];
      err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_x_mpc_rx_frame.sv
// Directed bench for x_mpc_rx_frame (WIDTH=8, CNT_W=4 so saturation is
// reachable quickly). Build with MPC_RX_PARITY_EN to exercise parity.
module tb_x_mpc_rx_frame;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef MPC_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic [WIDTH-1:0]  din1st, din2nd;
  logic              mpc_xmit;
  logic [3:0]        mpc_delay;
  logic              cnt_clear;
  logic              rsp_valid;
  logic [15:0]       rsp_frame0, rsp_frame1;
  logic [1:0]        rsp_accept;
  logic              rsp_idle_err, rsp_parity_err, busy;
  logic [CNT_W-1:0]  rsp_count, err_count;

  int checks = 0;
  int errors = 0;
  int exp_rsp = 0;
  int exp_err = 0;

  x_mpc_rx_frame #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .din1st(din1st), .din2nd(din2nd),
    .mpc_xmit(mpc_xmit), .mpc_delay(mpc_delay), .cnt_clear(cnt_clear),
    .rsp_valid(rsp_valid), .rsp_frame0(rsp_frame0), .rsp_frame1(rsp_frame1),
    .rsp_accept(rsp_accept), .rsp_idle_err(rsp_idle_err),
    .rsp_parity_err(rsp_parity_err), .busy(busy),
    .rsp_count(rsp_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic set_din(input logic [15:0] w);
    {din2nd, din1st} = w;
  endtask

  // Strobe before edge 0 with delay 3: frame0 sampled at edge 3, frame1 at
  // edge 4, rsp_valid high after edge 5. clr asserts cnt_clear on edge 5.
  task automatic send(input logic [15:0] d0, input logic [15:0] d1, input bit clr);
    bit idle, par;
    logic [1:0] acc;
    mpc_delay = 4'd3;
    mpc_xmit = 1'b1; tick;
    mpc_xmit = 1'b0; tick; tick;
    set_din(d0); tick;
    set_din(d1); tick;
    chk("busy_f1", 32'(busy), 32'd1);
    chk("valid_early", 32'(rsp_valid), 32'd0);
    set_din(16'hFFFF);
    cnt_clear = clr; tick;
    cnt_clear = 1'b0;
    idle = (d0 == 16'hFFFF) || (d1 == 16'hFFFF);
    acc  = idle ? 2'b00 : {d1[15], d0[15]};
    par  = PAR && ((^d0) || (^d1));
    exp_rsp = clr ? 0 : sat(exp_rsp + 1);
    exp_err = clr ? 0 : sat(exp_err + ((idle || par) ? 1 : 0));
    chk("valid", 32'(rsp_valid), 32'd1);
    chk("frame0", 32'(rsp_frame0), 32'(d0));
    chk("frame1", 32'(rsp_frame1), 32'(d1));
    chk("accept", 32'(rsp_accept), 32'(acc));
    chk("idle_err", 32'(rsp_idle_err), 32'(idle));
    chk("parity_err", 32'(rsp_parity_err), 32'(par));
    chk("rsp_count", 32'(rsp_count), 32'(exp_rsp));
    chk("err_count", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; mpc_xmit = 1'b0; mpc_delay = 4'd3; cnt_clear = 1'b0;
    set_din(16'hFFFF);
    tick; tick;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_frame0", 32'(rsp_frame0), 32'd0);
    chk("rst_frame1", 32'(rsp_frame1), 32'd0);
    chk("rst_accept", 32'(rsp_accept), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;

    // Idle line, no strobes: nothing happens
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rsp_valid || busy) seen++;
    end
    chk("idle_no_valid", 32'(seen), 32'd0);
    chk("idle_rsp_count", 32'(rsp_count), 32'd0);
    chk("idle_err_count", 32'(err_count), 32'd0);
    chk("idle_idle_err", 32'(rsp_idle_err), 32'd0);

    // Normal response
    send(16'h8123, 16'h0456, 1'b0);
    tick;
    chk("pulse_one_clk", 32'(rsp_valid), 32'd0);
    chk("hold_frame0", 32'(rsp_frame0), 32'h8123);
    chk("hold_accept", 32'(rsp_accept), 32'd1);
    tick;

    // Missing responses
    send(16'hFFFF, 16'hFFFF, 1'b0);
    tick; tick;
    send(16'h8123, 16'hFFFF, 1'b0);
    tick; tick;

    // Overlap: strobes one bx apart -> one response, one extra error
    mpc_delay = 4'd2;
    set_din(16'h8001);
    mpc_xmit = 1'b1; tick; tick;
    mpc_xmit = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    exp_rsp = sat(exp_rsp + 1);
    exp_err = sat(exp_err + 1);
    chk("ovl_valids", 32'(seen), 32'd1);
    chk("ovl_frame0", 32'(rsp_frame0), 32'h8001);
    chk("ovl_accept", 32'(rsp_accept), 32'd3);
    chk("ovl_rsp_count", 32'(rsp_count), 32'(exp_rsp));
    chk("ovl_err_count", 32'(err_count), 32'(exp_err));

    // Strobes two bx apart -> two clean responses
    mpc_xmit = 1'b1; tick;
    mpc_xmit = 1'b0; tick;
    mpc_xmit = 1'b1; tick;
    mpc_xmit = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    exp_rsp = sat(exp_rsp + 2);
    chk("gap2_valids", 32'(seen), 32'd2);
    chk("gap2_rsp_count", 32'(rsp_count), 32'(exp_rsp));
    chk("gap2_err_count", 32'(err_count), 32'(exp_err));
    set_din(16'hFFFF);

    // Saturation: clear, then 17 good responses -> 15
    cnt_clear = 1'b1; tick; cnt_clear = 1'b0;
    exp_rsp = 0; exp_err = 0;
    chk("clr_rsp_count", 32'(rsp_count), 32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      send(16'h8001, 16'h0003, 1'b0);
      tick;
    end
    chk("sat_rsp_count", 32'(rsp_count), 32'd15);

    // Clear wins over a same-edge increment
    send(16'h8001, 16'h0003, 1'b1);
    chk("clr_win_rsp", 32'(rsp_count), 32'd0);
    tick;

    // Odd-parity frame0 (error only when parity checking is built in)
    send(16'h0001, 16'h0003, 1'b0);
    chk("par_err_count", 32'(err_count), PAR ? 32'd1 : 32'd0);
    tick;

    // Reset while busy: capture aborted, no response
    mpc_delay = 4'd3;
    mpc_xmit = 1'b1; tick;
    mpc_xmit = 1'b0; tick; tick;
    set_din(16'h8001); tick;
    set_din(16'h0003); tick;
    chk("abort_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("abort_busy_rst", 32'(busy), 32'd0);
    set_din(16'hFFFF);
    tick;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_rsp_count", 32'(rsp_count), 32'd0);
    chk("abort_err_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
